// File: rtl/count_seq_checker.sv
// Receive-side monitor for a free-running counter bus: locks onto the +1 sequence,
// flags sequence errors and counter restarts, and keeps error/wrap statistics.
module count_seq_checker #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned LOCK_LEN  = 2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     count_in,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 restart_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ERR_CNT_W-1:0] wrap_count
);

    localparam int unsigned    GoodW    = $clog2(LOCK_LEN + 1);
    localparam logic [GoodW-1:0] GoodLast = GoodW'(LOCK_LEN - 1);
    localparam logic [WIDTH-1:0] CntMax   = '1;

    typedef enum logic [1:0] {
        StUnlocked,
        StAcquire,
        StLocked
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic [GoodW-1:0]     good_q, good_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic                 locked_q;
    logic                 err_pulse_q;
    logic                 restart_pulse_q;

    logic [WIDTH-1:0]     nxt;
    logic                 seq_ok;
    logic                 err_hit;
    logic                 restart_hit;
    logic                 wrap_hit;

    assign nxt    = prev_q + WIDTH'(1);
    assign seq_ok = (count_in == nxt);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_d      = good_q;
        err_hit     = 1'b0;
        restart_hit = 1'b0;
        wrap_hit    = 1'b0;

        if (en) begin
            prev_d = count_in;
            case (state_q)
                StUnlocked: begin
                    good_d  = '0;
                    state_d = StAcquire;
                end
                StAcquire: begin
                    // Mismatches while acquiring are silent; just restart the run.
                    if (seq_ok) begin
                        if (good_q == GoodLast) begin
                            good_d  = '0;
                            state_d = StLocked;
                        end else begin
                            good_d = good_q + GoodW'(1);
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                StLocked: begin
                    if (seq_ok) begin
                        wrap_hit = (prev_q == CntMax);
                    end else begin
                        good_d  = '0;
                        state_d = StAcquire;
                        // A jump to zero is a counter restart, not a corrupted bus.
                        if (count_in == '0) begin
                            restart_hit = 1'b1;
                        end else begin
                            err_hit = 1'b1;
                        end
                    end
                end
                default: begin
                    good_d  = '0;
                    state_d = StUnlocked;
                end
            endcase
        end
    end

    always_comb begin
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        if (clr) begin
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
        end else begin
            if (err_hit && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            if (wrap_hit) begin
                wrap_cnt_d = wrap_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StUnlocked;
            prev_q          <= '0;
            good_q          <= '0;
            err_cnt_q       <= '0;
            wrap_cnt_q      <= '0;
            locked_q        <= 1'b0;
            err_pulse_q     <= 1'b0;
            restart_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            prev_q          <= prev_d;
            good_q          <= good_d;
            err_cnt_q       <= err_cnt_d;
            wrap_cnt_q      <= wrap_cnt_d;
            locked_q        <= (state_d == StLocked);
            err_pulse_q     <= err_hit;
            restart_pulse_q <= restart_hit;
        end
    end

    assign locked        = locked_q;
    assign err_pulse     = err_pulse_q;
    assign restart_pulse = restart_pulse_q;
    assign err_count     = err_cnt_q;
    assign wrap_count    = wrap_cnt_q;

endmodule
